// File: rtl/nmos_pmos_dlatch_pkg.sv
// Shared constants and types for the complementary-output D storage bank.
package nmos_pmos_dlatch_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   // Storage behaviour of each bit: level-sensitive latch or rising-edge flop
   typedef enum logic {
      LATCH = 1'b0,
      FLOP  = 1'b1
   } edge_mode_e;

endpackage

// File: rtl/nmos_pmos_dlatch_if.sv
// Data bus of the storage bank: D in, complementary Q/Q_n out.
interface nmos_pmos_dlatch_if
   import nmos_pmos_dlatch_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Q_n;

   modport master (output D, input Q, input Q_n);
   modport slave  (input D, output Q, output Q_n);
endinterface

// File: rtl/mos_nand2.sv
// NAND2 built as two parallel pmos pull-ups from vdd and two series nmos pull-downs to vss.
module mos_nand2 #(
   parameter int unsigned GATE_DLY = 0
) (
   input  logic a,
   input  logic b,
   output logic y_c
);
   logic pu_on_c;
   logic pd_on_c;

   // Either low input turns on a pmos; both inputs high complete the nmos stack
   assign pu_on_c = ~a | ~b;
   assign pd_on_c = a & b;
   assign y_c     = pu_on_c & ~pd_on_c;

   // Propagation delay is a gate-level annotation only; this model stays zero-delay
   if (GATE_DLY > 0) begin : g_dly_sim_only
   end
endmodule

// File: rtl/nmos_pmos_dlatch_cell.sv
// One gated-D bit: five NAND2 gates with reset folded into the set/reset rails.
module nmos_pmos_dlatch_cell #(
   parameter int unsigned GATE_DLY = 0
) (
   input  logic en,
   input  logic rst_n,
   input  logic d,
   output logic q_c,
   output logic qn_c
);
   logic set_n_c;
   logic dn_c;
   logic rst_int_n_c;
   logic set_g_c;
   logic rst_g_c;
   logic lat_en_c;
   logic state_d;
   logic state_q;

   mos_nand2 #(.GATE_DLY(GATE_DLY)) u_set (.a(en),   .b(d),  .y_c(set_n_c));
   mos_nand2 #(.GATE_DLY(GATE_DLY)) u_dn  (.a(d),    .b(d),  .y_c(dn_c));
   mos_nand2 #(.GATE_DLY(GATE_DLY)) u_rst (.a(dn_c), .b(en), .y_c(rst_int_n_c));

   // Reset holds the set rail inactive and the reset rail active
   assign set_g_c = set_n_c | ~rst_n;
   assign rst_g_c = rst_int_n_c & rst_n;

   // Storage node of the cross-coupled pair, written whenever either rail pulls low
   always_comb begin
      lat_en_c = 1'b0;
      state_d  = 1'b0;
      lat_en_c = ~set_g_c | ~rst_g_c;
      state_d  = ~set_g_c;
   end

   always_latch begin
      if (lat_en_c) state_q <= state_d;
   end

   mos_nand2 #(.GATE_DLY(GATE_DLY)) u_q  (.a(set_g_c), .b(qn_c),    .y_c(q_c));
   mos_nand2 #(.GATE_DLY(GATE_DLY)) u_qn (.a(rst_g_c), .b(state_q), .y_c(qn_c));
endmodule

// File: rtl/nmos_pmos_dlatch.sv
// WIDTH-bit D storage bank with complementary outputs; latch or master-slave flop per EDGE_MODE.
module nmos_pmos_dlatch
   import nmos_pmos_dlatch_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter edge_mode_e  EDGE_MODE = LATCH,
   parameter int unsigned GATE_DLY  = 0
) (
   input logic               clk,
   input logic               rst_n,
   nmos_pmos_dlatch_if.slave bus
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (EDGE_MODE == FLOP) begin : g_flop
         logic m_q_c;
         logic m_qn_unused_c;

         // Master is open while clk is low, so the slave sees D as it was at the rising edge
         nmos_pmos_dlatch_cell #(.GATE_DLY(GATE_DLY)) u_master (
            .en    (~clk),
            .rst_n (rst_n),
            .d     (bus.D[i]),
            .q_c   (m_q_c),
            .qn_c  (m_qn_unused_c)
         );
         nmos_pmos_dlatch_cell #(.GATE_DLY(GATE_DLY)) u_slave (
            .en    (clk),
            .rst_n (rst_n),
            .d     (m_q_c),
            .q_c   (bus.Q[i]),
            .qn_c  (bus.Q_n[i])
         );
      end else begin : g_latch
         nmos_pmos_dlatch_cell #(.GATE_DLY(GATE_DLY)) u_cell (
            .en    (clk),
            .rst_n (rst_n),
            .d     (bus.D[i]),
            .q_c   (bus.Q[i]),
            .qn_c  (bus.Q_n[i])
         );
      end
   end
endmodule

// File: tb/tb_nmos_pmos_dlatch.sv
// Directed + random bench for nmos_pmos_dlatch in latch and flop modes, WIDTH 4 and 1.
module tb_nmos_pmos_dlatch;
   import nmos_pmos_dlatch_pkg::*;

   typedef struct {
      string      tag;
      logic [3:0] exp;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  d;
   logic [3:0]  m_l;
   logic [3:0]  m_f;
   sb_t         sb[$];
   int unsigned n_pass;
   int unsigned n_total;

   nmos_pmos_dlatch_if #(.WIDTH(4)) bus_l4 ();
   nmos_pmos_dlatch_if #(.WIDTH(4)) bus_f4 ();
   nmos_pmos_dlatch_if #(.WIDTH(1)) bus_l1 ();
   nmos_pmos_dlatch_if #(.WIDTH(1)) bus_f1 ();

   nmos_pmos_dlatch #(.WIDTH(4), .EDGE_MODE(LATCH), .GATE_DLY(0)) dut_l4 (
      .clk(clk), .rst_n(rst_n), .bus(bus_l4));
   nmos_pmos_dlatch #(.WIDTH(4), .EDGE_MODE(FLOP), .GATE_DLY(0)) dut_f4 (
      .clk(clk), .rst_n(rst_n), .bus(bus_f4));
   nmos_pmos_dlatch #(.WIDTH(1), .EDGE_MODE(LATCH), .GATE_DLY(2)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .bus(bus_l1));
   nmos_pmos_dlatch #(.WIDTH(1), .EDGE_MODE(FLOP), .GATE_DLY(2)) dut_f1 (
      .clk(clk), .rst_n(rst_n), .bus(bus_f1));

   task automatic push1(input string tag, input logic [3:0] v);
      sb_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   // Expected outputs of all four instances from the behavioural models
   task automatic push_exp(input string tag);
      push1({tag, ".l4.Q"},  m_l);
      push1({tag, ".l4.Qn"}, ~m_l);
      push1({tag, ".f4.Q"},  m_f);
      push1({tag, ".f4.Qn"}, ~m_f);
      push1({tag, ".l1.Q"},  {3'b000, m_l[0]});
      push1({tag, ".l1.Qn"}, {3'b000, ~m_l[0]});
      push1({tag, ".f1.Q"},  {3'b000, m_f[0]});
      push1({tag, ".f1.Qn"}, {3'b000, ~m_f[0]});
   endtask

   task automatic pop_cmp(input logic [3:0] obs);
      sb_t e;
      n_total++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) n_pass++;
         else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask

   task automatic settle_check();
      #10;
      pop_cmp(bus_l4.Q);
      pop_cmp(bus_l4.Q_n);
      pop_cmp(bus_f4.Q);
      pop_cmp(bus_f4.Q_n);
      pop_cmp({3'b000, bus_l1.Q});
      pop_cmp({3'b000, bus_l1.Q_n});
      pop_cmp({3'b000, bus_f1.Q});
      pop_cmp({3'b000, bus_f1.Q_n});
   endtask

   task automatic drive_d(input logic [3:0] v, input string tag);
      d         = v;
      bus_l4.D  = v;
      bus_f4.D  = v;
      bus_l1.D  = v[0];
      bus_f1.D  = v[0];
      if (rst_n && clk) m_l = v;
      push_exp(tag);
      settle_check();
   endtask

   task automatic drive_clk(input logic v, input string tag);
      if (rst_n && v && !clk) m_f = d;
      clk = v;
      if (rst_n && v) m_l = d;
      push_exp(tag);
      settle_check();
   endtask

   task automatic drive_rst(input logic v, input string tag);
      rst_n = v;
      if (!v) begin
         m_l = 4'h0;
         m_f = 4'h0;
      end else if (clk) begin
         m_l = d;
      end
      push_exp(tag);
      settle_check();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      m_l     = 4'h0;
      m_f     = 4'h0;
      rst_n   = 1'b0;
      clk     = 1'b1;

      // Reset dominates a transparent latch with D all ones
      drive_d(4'hF, "reset");
      drive_clk(1'b0, "rst_hold0");
      drive_clk(1'b1, "rst_hold1");
      drive_clk(1'b0, "rst_hold2");
      drive_clk(1'b1, "rst_hold3");
      drive_rst(1'b1, "rel_clk_hi");

      // Transparency with clk held high
      for (int k = 0; k < 6; k++) begin
         #190;
         drive_d((k % 2 == 0) ? 4'h5 : 4'hA, "transp");
      end

      // Hold while clk low, then reopen
      drive_d(4'h3, "hold_d3");
      drive_clk(1'b0, "hold_fall");
      for (int k = 0; k < 10; k++) begin
         #190;
         drive_d((k % 2 == 0) ? 4'h5 : 4'hA, "hold_tog");
      end
      drive_d(4'hC, "hold_dC");
      drive_clk(1'b1, "hold_rise");

      // Edge capture with a 4000-unit period
      drive_clk(1'b0, "ff_fall");
      #1780;
      drive_d(4'h9, "ff_d9");
      #190;
      drive_clk(1'b1, "ff_rise9");
      #990;
      drive_d(4'h6, "ff_mid");
      #990;
      drive_clk(1'b0, "ff_fall2");
      #1990;
      drive_clk(1'b1, "ff_rise6");

      // Reset asserted mid-high, released with clk high
      drive_d(4'hF, "pre_rst_d");
      drive_clk(1'b0, "pre_rst_fall");
      drive_clk(1'b1, "pre_rst_rise");
      drive_rst(1'b0, "rst_mid");
      drive_d(4'hA, "rst_dA");
      drive_rst(1'b1, "rel_hi");
      drive_clk(1'b0, "rel_hi_fall");
      drive_clk(1'b1, "rel_hi_rise");

      // Reset released with clk low
      drive_rst(1'b0, "rst_lo");
      drive_clk(1'b0, "rst_lo_fall");
      drive_d(4'h7, "rst_lo_d7");
      drive_rst(1'b1, "rel_lo");
      drive_clk(1'b1, "rel_lo_rise");

      // Random clk/D activity, never changing both at once
      for (int k = 0; k < 150; k++) begin
         #($urandom_range(10, 90));
         if ($urandom_range(0, 1) == 1) drive_clk(~clk, "rnd_clk");
         else                          drive_d(4'($urandom), "rnd_d");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
